sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised synchronous FIFO with first-word-fall-through output and occupancy count. Adds programmable almost-full/almost-empty thresholds, a synchronous flush, and sticky overflow/underflow error flags. It is the general-purpose buffering block between producer and consumer logic in one clock domain, replacing fixed 4×8-bit shift-register FIFOs.

## Interface
- DATA_W, 8: data word width in bits (≥1)
- DEPTH, 16: number of entries; power of two, ≥2
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL (1..DEPTH)
- AE_LEVEL, 1: almost_empty asserts when count ≤ AE_LEVEL (0..DEPTH-1)
- CNT_W, $clog2(DEPTH)+1: derived localparam, count width
- clk  in  1  rising-edge clock; single clock domain
- reset_n  in  1  asynchronous, active-low reset
- flush  in  1  synchronous flush, empties FIFO
- clr_err  in  1  synchronous clear of overflow/underflow
- push  in  1  write data_in this cycle
- data_in  in  DATA_W  write data
- pop  in  1  consume head entry this cycle
- data_out  out  DATA_W  head entry (FWFT); 0 when empty
- fifo_full  out  1  count == DEPTH
- fifo_empty  out  1  count == 0
- almost_full  out  1  count ≥ AF_LEVEL
- almost_empty  out  1  count ≤ AE_LEVEL
- count  out  CNT_W  current occupancy, 0..DEPTH
- overflow  out  1  sticky: push attempted while full without pop
- underflow  out  1  sticky: pop attempted while empty

## Operation
- Storage: DEPTH×DATA_W register array; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count register CNT_W bits.
- Reset (reset_n low, async): wr_ptr=rd_ptr=0, count=0, overflow=underflow=0. Outputs: fifo_empty=1, fifo_full=0, almost_empty=1, almost_full=(AF_LEVEL==0 ? n/a : 0), count=0, data_out=0. Memory contents not reset.
- Priority per cycle: flush > push/pop. flush=1: pointers and count to 0; push/pop that cycle ignored and do not set error flags.
- Accepted push: mem[wr_ptr]<=data_in, wr_ptr+1. Accepted when count<DEPTH, or when full and pop also asserted (simultaneous push+pop on full: both performed, count unchanged).
- Rejected push (full, no pop): no state change except overflow<=1.
- Accepted pop: rd_ptr+1. Accepted when count>0. Pop while empty: ignored, underflow<=1; a simultaneous push is still accepted (count 0→1).
- Count: +1 push-only, −1 pop-only, unchanged on both or neither; never exceeds DEPTH or drops below 0.
- Error flags: set as above; clr_err=1 clears both; if a new error event occurs in the same cycle as clr_err, the flag is set (set wins).
- Status flags are decoded combinationally from the count register only (no combinational path from push/pop/data_in to any output).
- data_out = mem[rd_ptr] when count>0, else 0.

## Timing
- Write-to-read latency: word pushed at edge N is visible on data_out after edge N (FWFT) if FIFO was empty; pop at edge N+1 consumes it.
- All status outputs and count update on the same edge as the push/pop/flush that changes them.
- Pop-to-next-word: after a pop at edge N, data_out shows the next entry immediately after edge N.
- reset_n assertion mid-operation: all state clears asynchronously; deassertion synchronous to design by upstream reset synchroniser; first push accepted on first clk edge with reset_n high.
- Throughput: one push and one pop per cycle, sustained, at any fill level.

## Test plan
- Reset: assert reset_n=0 mid-transfer with count=5 -> count=0, fifo_empty=1, data_out=0, overflow=underflow=0 without clock edge.
- Fill/drain (DATA_W=8, DEPTH=16): push 0x01..0x10 -> fifo_full=1 and count=16 after 16th edge, almost_full=1 from count 14; pop 16 times -> data_out sequence 0x01..0x10, then fifo_empty=1.
- Wrap-around: push 10, pop 10, push 12, pop 12 -> order preserved across pointer wrap, count returns to 0.
- Simultaneous: full FIFO, push 0xAA + pop together -> count stays 16, overflow=0, 0xAA emerges last; empty FIFO, push 0x55 + pop -> count=1, data_out=0x55, underflow=1.
- Errors: push on full -> overflow=1, contents unchanged; clr_err -> overflow=0; clr_err with simultaneous pop-on-empty -> underflow=1.
- Flush: count=7, flush with push asserted -> count=0, fifo_empty=1, no overflow; next push 0x3C -> data_out=0x3C.

Source files
------------

// File: rtl/sync_fifo_param_if.sv
// Port bundle between a producer/consumer (master) and sync_fifo_param (slave).
// CNT_W must equal $clog2(DEPTH)+1 of the FIFO this bundle is connected to.
interface sync_fifo_param_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 5
);
    logic              flush;
    logic              clr_err;
    logic              push;
    logic [DATA_W-1:0] data_in;
    logic              pop;
    logic [DATA_W-1:0] data_out;
    logic              fifo_full;
    logic              fifo_empty;
    logic              almost_full;
    logic              almost_empty;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              underflow;

    modport master (
        output flush, clr_err, push, data_in, pop,
        input  data_out, fifo_full, fifo_empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  flush, clr_err, push, data_in, pop,
        output data_out, fifo_full, fifo_empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Single-clock first-word-fall-through FIFO with occupancy count, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_param #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 16,
    parameter int AF_LEVEL = DEPTH - 2,
    parameter int AE_LEVEL = 1
) (
    input logic                clk,
    input logic                reset_n,
    sync_fifo_param_if.slave   bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;

    logic full;
    logic empty;
    logic do_push;
    logic do_pop;
    logic overflow_evt;
    logic underflow_evt;

    // Acceptance is decided from the registered count only; a pop on a full
    // FIFO frees the slot the simultaneous push lands in.
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        full          = (count_q == CNT_W'(DEPTH));
        empty         = (count_q == '0);
        do_push       = 1'b0;
        do_pop        = 1'b0;
        overflow_evt  = 1'b0;
        underflow_evt = 1'b0;
        if (!bus.flush) begin
            do_pop        = bus.pop && !empty;
            do_push       = bus.push && (!full || bus.pop);
            overflow_evt  = bus.push && full && !bus.pop;
            underflow_evt = bus.pop && empty;
        end
    end

    // NOTE: the storage array has no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= bus.data_in;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // A new error event in the same cycle as clr_err leaves the flag set.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            overflow_q  <= overflow_evt  || (overflow_q  && !bus.clr_err);
            underflow_q <= underflow_evt || (underflow_q && !bus.clr_err);
        end
    end

    assign bus.data_out     = empty ? '0 : mem[rd_ptr];
    assign bus.fifo_full    = full;
    assign bus.fifo_empty   = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LEVEL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LEVEL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: a queue-based model predicts state and
// popped words; a negedge monitor compares every word the DUT hands out.
module tb_sync_fifo_param;
    localparam int DATA_W   = 8;
    localparam int DEPTH    = 16;
    localparam int AF_LEVEL = DEPTH - 2;
    localparam int AE_LEVEL = 1;
    localparam int CNT_W    = $clog2(DEPTH) + 1;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    int   checks  = 0;
    int   errors  = 0;

    logic [DATA_W-1:0] model_q [$];
    logic [DATA_W-1:0] exp_q   [$];
    bit                model_ovf = 1'b0;
    bit                model_unf = 1'b0;

    sync_fifo_param_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

    sync_fifo_param #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .AF_LEVEL(AF_LEVEL),
        .AE_LEVEL(AE_LEVEL)
    ) dut (
        .clk    (clk),
        .reset_n(reset_n),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_status();
        int n;
        n = model_q.size();
        check("count",        32'(bus.count),        32'(n));
        check("fifo_full",    32'(bus.fifo_full),    32'(n == DEPTH));
        check("fifo_empty",   32'(bus.fifo_empty),   32'(n == 0));
        check("almost_full",  32'(bus.almost_full),  32'(n >= AF_LEVEL));
        check("almost_empty", 32'(bus.almost_empty), 32'(n <= AE_LEVEL));
        check("overflow",     32'(bus.overflow),     32'(model_ovf));
        check("underflow",    32'(bus.underflow),    32'(model_unf));
        check("head",         32'(bus.data_out),     (n == 0) ? 32'd0 : 32'(model_q[0]));
    endtask

    // Drive one cycle's request, advance the model, clock it in, compare state.
    task automatic cycle(input bit p, input bit r, input logic [DATA_W-1:0] d,
                         input bit f, input bit c);
        bit ovf_ev;
        bit unf_ev;
        bus.push    = p;
        bus.pop     = r;
        bus.data_in = d;
        bus.flush   = f;
        bus.clr_err = c;
        ovf_ev = 1'b0;
        unf_ev = 1'b0;
        if (f) begin
            model_q.delete();
        end else begin
            ovf_ev = p && !r && (model_q.size() == DEPTH);
            unf_ev = r && (model_q.size() == 0);
            if (r && model_q.size() > 0) exp_q.push_back(model_q.pop_front());
            if (p && !ovf_ev) model_q.push_back(d);
        end
        model_ovf = ovf_ev || (model_ovf && !c);
        model_unf = unf_ev || (model_unf && !c);
        @(posedge clk);
        #1;
        check_status();
    endtask

    // Monitor: each accepted pop must hand out the next predicted word.
    always @(negedge clk) begin
        if (reset_n && bus.pop && !bus.flush && !bus.fifo_empty) begin
            check("pop_pending", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("pop_data", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int push_pct;
        int pop_pct;
        bus.push    = 1'b0;
        bus.pop     = 1'b0;
        bus.data_in = '0;
        bus.flush   = 1'b0;
        bus.clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_status();
        reset_n = 1'b1;

        // Fill 0x01..0x10, then push 0xAA with a pop on full, then drain.
        for (int i = 1; i <= DEPTH; i++) cycle(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
        check("fill_count", 32'(bus.count), 32'd16);
        check("fill_full",  32'(bus.fifo_full), 32'd1);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0, 1'b0);
        check("simul_full_count", 32'(bus.count), 32'd16);
        check("simul_full_ovf",   32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("drain_empty", 32'(bus.fifo_empty), 32'd1);

        // Push on full sets overflow without changing contents; clr_err clears it.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h40 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0, 1'b0);
        check("ovf_set", 32'(bus.overflow), 32'd1);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        check("ovf_clr", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);

        // Push+pop on empty: push lands, pop flags underflow.
        cycle(1'b1, 1'b1, 8'h55, 1'b0, 1'b0);
        check("simul_empty_count", 32'(bus.count), 32'd1);
        check("simul_empty_data",  32'(bus.data_out), 32'h55);
        check("simul_empty_unf",   32'(bus.underflow), 32'd1);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("unf_cleared", 32'(bus.underflow), 32'd0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
        check("unf_set_wins", 32'(bus.underflow), 32'd1);

        // Pointer wrap-around.
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i), 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("wrap_count", 32'(bus.count), 32'd0);

        // Flush wins over a simultaneous push.
        for (int i = 0; i < 7; i++) cycle(1'b1, 1'b0, 8'(8'hC0 + i), 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 8'h99, 1'b1, 1'b0);
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_empty", 32'(bus.fifo_empty), 32'd1);
        cycle(1'b1, 1'b0, 8'h3C, 1'b0, 1'b0);
        check("post_flush_data", 32'(bus.data_out), 32'h3C);

        // Asynchronous reset mid-transfer with count 5 and flags set.
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'hD0 + i), 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) cycle(1'b1, 1'b0, 8'hF0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'hF1, 1'b0, 1'b0);
        check("pre_reset_count", 32'(bus.count), 32'd7);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        check("reset_count_5", 32'(bus.count), 32'd5);
        bus.push = 1'b0;
        bus.pop  = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_count",     32'(bus.count), 32'd0);
        check("rst_empty",     32'(bus.fifo_empty), 32'd1);
        check("rst_data",      32'(bus.data_out), 32'd0);
        check("rst_overflow",  32'(bus.overflow), 32'd0);
        check("rst_underflow", 32'(bus.underflow), 32'd0);
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check_status();

        // Randomised traffic in push-heavy, pop-heavy and balanced phases.
        for (int ph = 0; ph < 3; ph++) begin
            case (ph)
                0:       begin push_pct = 80; pop_pct = 30; end
                1:       begin push_pct = 30; pop_pct = 80; end
                default: begin push_pct = 60; pop_pct = 60; end
            endcase
            for (int i = 0; i < 200; i++) begin
                cycle($urandom_range(99) < push_pct, $urandom_range(99) < pop_pct,
                      8'($urandom), $urandom_range(99) < 2, $urandom_range(99) < 5);
            end
        end

        for (int i = 0; i < DEPTH + 1; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
